// File: rtl/score_keeper.sv
// Game-score accumulator: turns gameplay event strobes into a saturating score,
// a persistent high score, the ghost-chain popup value and a one-shot extra life.
module score_keeper #(
  parameter logic [15:0] MAX_SCORE      = 16'd9999,
  parameter logic [15:0] PELLET_PTS     = 16'd10,
  parameter logic [15:0] POWER_PTS      = 16'd50,
  parameter logic [10:0] GHOST_BASE_PTS = 11'd200,
  parameter logic [15:0] EXTRA_LIFE_AT  = 16'd5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MODE,
  input  logic        pellet_eaten,
  input  logic        power_eaten,
  input  logic        ghost_eaten,
  input  logic        fright_end,
  input  logic        fruit_eaten,
  input  logic [10:0] fruit_pts,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic        extra_life,
  output logic [10:0] ghost_pts
);

  localparam logic [1:0] GAME_MODE_LOADING = 2'd0;
  localparam logic [1:0] GAME_MODE_READY   = 2'd1;
  localparam logic [1:0] GAME_MODE_PLAYING = 2'd2;
  localparam logic [1:0] GAME_MODE_FAIL    = 2'd3;

  logic [15:0] score_r;
  logic [15:0] high_score_r;
  logic        extra_life_r;
  logic [10:0] ghost_pts_r;
  logic [1:0]  chain_idx_r;
  logic        life_awarded_r;
  logic [1:0]  mode_r;

  logic        playing_s;
  logic        new_game_s;
  logic [16:0] ghost_val_s;
  logic [16:0] add_s;
  logic [16:0] sum_s;
  logic [15:0] nxt_s;
  logic [1:0]  chain_nxt_s;
  logic        life_hit_s;

  // Decode mode, form the per-cycle point sum and the saturated next score.
  always_comb begin
    playing_s   = 1'b0;
    new_game_s  = 1'b0;
    ghost_val_s = {6'd0, GHOST_BASE_PTS} << chain_idx_r;
    add_s       = 17'd0;
    case (MODE)
      GAME_MODE_PLAYING: playing_s  = 1'b1;
      GAME_MODE_READY:   new_game_s = (mode_r != GAME_MODE_READY);
      GAME_MODE_LOADING: playing_s  = 1'b0;
      GAME_MODE_FAIL:    playing_s  = 1'b0;
      default:           playing_s  = 1'b0;
    endcase
    if (pellet_eaten) add_s = add_s + {1'b0, PELLET_PTS};
    else              add_s = add_s;
    if (power_eaten)  add_s = add_s + {1'b0, POWER_PTS};
    else              add_s = add_s;
    if (ghost_eaten)  add_s = add_s + ghost_val_s;
    else              add_s = add_s;
    if (fruit_eaten)  add_s = add_s + {6'd0, fruit_pts};
    else              add_s = add_s;
    sum_s = {1'b0, score_r} + add_s;
    if (sum_s > {1'b0, MAX_SCORE}) nxt_s = MAX_SCORE;
    else                           nxt_s = sum_s[15:0];
    // A chain restart wins over a same-cycle ghost; that ghost was already paid at the old index.
    if (power_eaten || fright_end)            chain_nxt_s = 2'd0;
    else if (ghost_eaten && chain_idx_r != 2'd3) chain_nxt_s = chain_idx_r + 2'd1;
    else                                       chain_nxt_s = chain_idx_r;
    life_hit_s = !life_awarded_r && (score_r < EXTRA_LIFE_AT) && (nxt_s >= EXTRA_LIFE_AT);
  end

  // Score, high score, chain and extra-life state.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_r        <= 16'd0;
      high_score_r   <= 16'd0;
      extra_life_r   <= 1'b0;
      ghost_pts_r    <= 11'd0;
      chain_idx_r    <= 2'd0;
      life_awarded_r <= 1'b0;
      mode_r         <= GAME_MODE_LOADING;
    end else begin
      mode_r       <= MODE;
      extra_life_r <= 1'b0;
      if (new_game_s) begin
        score_r        <= 16'd0;
        chain_idx_r    <= 2'd0;
        life_awarded_r <= 1'b0;
      end else if (playing_s) begin
        score_r     <= nxt_s;
        chain_idx_r <= chain_nxt_s;
        if (nxt_s > high_score_r) high_score_r <= nxt_s;
        if (life_hit_s) begin
          extra_life_r   <= 1'b1;
          life_awarded_r <= 1'b1;
        end
        if (ghost_eaten) ghost_pts_r <= ghost_val_s[10:0];
      end
    end
  end

  assign score      = score_r;
  assign high_score = high_score_r;
  assign extra_life = extra_life_r;
  assign ghost_pts  = ghost_pts_r;

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-score accumulator sitting directly upstream of the on-screen text overlay. It converts single-cycle gameplay event strobes into a saturating binary score and a persistent high score, both 16-bit and both fed to the overlay's BCD/ASCII path. It also implements the ghost-eating point chain and a one-shot extra-life award.

## Interface
- `MAX_SCORE`, 9999: saturation ceiling. The overlay renders 4 decimal digits.
- `PELLET_PTS`, 10: points per pellet.
- `POWER_PTS`, 50: points per power pellet.
- `GHOST_BASE_PTS`, 200: first ghost in a chain. Each later ghost doubles the value, capped at the 4th (1600).
- `EXTRA_LIFE_AT`, 5000: threshold for the extra-life award.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `MODE`  in  game_mode_t  current game mode.
- `pellet_eaten`  in  1  one-cycle strobe.
- `power_eaten`  in  1  one-cycle strobe. Also restarts the ghost chain.
- `ghost_eaten`  in  1  one-cycle strobe.
- `fright_end`  in  1  one-cycle strobe marking the end of frightened time. Restarts the ghost chain.
- `fruit_eaten`  in  1  one-cycle strobe.
- `fruit_pts`  in  11  fruit value in points, 0..2047.
- `score`  out  16  current score, binary.
- `high_score`  out  16  best score since reset, binary.
- `extra_life`  out  1  one-cycle pulse.
- `ghost_pts`  out  11  value of the last ghost eaten. Used for a sprite popup.

## Operation
- Reset: `score`=0, `high_score`=0, `extra_life`=0, `ghost_pts`=0, chain index=0, `life_awarded`=0.
- New game: on the first cycle `MODE`==GAME_MODE_READY while the previous-cycle `MODE`!=GAME_MODE_READY:
  - `score`, chain index and `life_awarded` clear to 0.
  - `high_score` is retained.
  - A registered copy of `MODE` provides the edge detect. After reset the copy is GAME_MODE_LOADING.
- Scoring is enabled only when `MODE`==GAME_MODE_PLAYING. In any other mode all strobes are ignored and the chain index is held.
- Per-cycle sum `add` is 17 bits unsigned, formed as the sum of:
  - PELLET_PTS if `pellet_eaten`
  - POWER_PTS if `power_eaten`
  - GHOST_BASE_PTS << idx if `ghost_eaten`, where idx is the current chain index (0..3)
  - `fruit_pts` if `fruit_eaten`
  - All strobes may assert in the same cycle, and all contribute.
- Next score: `nxt` = min(`score` + `add`, MAX_SCORE), computed at 17 bits, then truncated to 16.
- Chain index update, in priority order:
  - `power_eaten` or `fright_end` → 0. This also applies in a cycle with `ghost_eaten`, but that ghost is still paid at the old idx.
  - Otherwise `ghost_eaten` → min(idx+1, 3).
- `ghost_pts` is set to GHOST_BASE_PTS << idx (old idx) on every scored ghost. Otherwise it holds.
- `high_score` is set to `nxt` in the same cycle whenever `nxt` > `high_score`.
- Extra life fires once per game:
  - Condition: `life_awarded`==0 and `score` < EXTRA_LIFE_AT <= `nxt`.
  - Action: `extra_life` pulses for 1 cycle and `life_awarded` is set.
- Saturation: once `score`==MAX_SCORE it stays there until new game or reset. Further events still advance the chain and update `ghost_pts`.

## Timing
- All outputs are registered. A strobe in cycle N is reflected in `score`, `high_score`, `extra_life` and `ghost_pts` in cycle N+1.
- The overlay adds its own 1-cycle font latency. Score changes are not frame-synchronised; a mid-frame change is acceptable.
- `rst` overrides everything, including strobes in the same cycle.
- The new-game clear overrides strobes in the same cycle. They are dropped, because `MODE` is READY and not PLAYING.
- `extra_life` is never high for 2 consecutive cycles.

## Test plan
- Reset, then hold `MODE`=PLAYING with 3 `pellet_eaten` pulses → `score`=30, `high_score`=30, `extra_life`=0, each update 1 cycle after its strobe.
- `power_eaten`, then 5 `ghost_eaten` pulses → `score` increments 50, 200, 400, 800, 1600, 1600 (total 4650); `ghost_pts` ends at 1600. Then `fright_end` followed by `ghost_eaten` → +200.
- Same-cycle `pellet_eaten`+`power_eaten`+`ghost_eaten`(idx 2)+`fruit_eaten`(`fruit_pts`=100) → `score` +960 (10+50+800+100), and idx becomes 0.
- Preload `score`=4990, then one `pellet_eaten` → `score`=5000 and a single `extra_life` pulse. Cross 5000 again after a later drop/regain within the same game → no second pulse.
- `score`=9990, `fruit_eaten` with `fruit_pts`=2000 → `score`=9999. A further pellet → stays 9999; `high_score`=9999.
- Game over (FAIL) then READY with `score`=1234 and `high_score`=1234 → `score`=0, `high_score`=1234. Strobes during READY or LOADING → no change.
